count_preset_sched: RTL and testbench
=====================================

# count_preset_sched

Upstream sequencer for the 4-bit loadable counter.
- Accepts preset requests over a valid/ready handshake and queues them in a small FIFO.
- Drives the counter's `load`/`load_data` pair, either immediately or when the counter's `count` reaches a requested trigger value.
- Confirms that each load took effect by checking `count` one cycle after the load pulse.
- Sits between the control/host logic and the counter; its `load`, `load_data` and `count` ports connect one-to-one to the counter's ports of the same names.

## Interface
- `WIDTH`, 4, counter width; widths of preset, trigger, `count` and `load_data`.
- `DEPTH`, 4, request FIFO entries; power of two, ≥2.
- Reset is synchronous and active-high. `reset` is sampled only on the rising edge of `clk`.
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  synchronous active-high reset.
- `flush`  in  1  synchronous discard of the queued request and the in-flight request.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  `!full && !reset` (combinational).
- `req_preset`  in  WIDTH  value to load into the counter.
- `req_trigger`  in  WIDTH  `count` value that fires the load.
- `req_immediate`  in  1  fire on the first ARM cycle; ignore trigger.
- `count`  in  WIDTH  counter output.
- `load`  out  1  registered one-cycle load pulse to the counter.
- `load_data`  out  WIDTH  registered; valid while `load`=1, holds last value otherwise.
- `done`  out  1  registered one-cycle pulse: a load completed.
- `err`  out  1  registered one-cycle pulse, coincident with `done`: `count` != preset after the load.
- `busy`  out  1  state != IDLE.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: `req_valid && req_ready` at a clock edge writes {preset, trigger, immediate}. When full, the request is refused, including when a pop happens in the same cycle.
- Pop: the FSM pops the head when entering ARM. A push and a pop in the same cycle leave `level` unchanged.
- FSM states are IDLE, ARM, LOAD, CHECK.
- IDLE: when `level`>0, pop the head into holding registers and go to ARM.
- ARM: if `immediate`, or `count` == trigger in this cycle, go to LOAD; otherwise stay. There is no timeout; a trigger never reached holds ARM until `flush` or `reset`.
- LOAD: `load`=1 and `load_data`=preset for exactly this cycle; go to CHECK.
- CHECK: compare `count` with preset.
  - Next cycle: `done`=1, and `err`=1 on mismatch.
  - If `level`>0, pop the next entry and go directly to ARM. Otherwise go to IDLE.
- `flush`:
  - Empties the FIFO, drops the held entry and returns to IDLE.
  - Next-cycle `load`=0 and `done`=0. A flush in CHECK suppresses that `done`/`err`.
  - A push in the same cycle as `flush` is discarded.
  - Priority: `reset` > `flush` > push/pop.
- Trigger compare is full-width equality with no wrap handling. A trigger of 0 matches after the counter wraps 15→0.

## Timing
- Reset values: state=IDLE, `load`=0, `load_data`=0, `done`=0, `err`=0, `busy`=0, `level`=0, FIFO pointers=0. `req_ready`=0 while `reset`=1.
- Reset mid-operation:
  - Aborts everything; no `done` is emitted.
  - If `load` was high in the reset cycle, it is low in the next cycle.
- Immediate request on an idle, empty block, pushed at edge E0:
  - IDLE sees `level`=1 in cycle 1; pop at E1.
  - ARM in cycle 2; `load` high in cycle 3.
  - `count`=preset in cycle 4 (CHECK); `done` in cycle 5.
- Triggered load: ARM in cycle N with `count`==trigger gives `load` in N+1, CHECK in N+2, `done` in N+3.
- Back-to-back requests: the next entry is in ARM in the same cycle that `done` pulses. The minimum spacing between `load` pulses is 3 cycles.
- `busy`=1 from the first ARM cycle through the last CHECK cycle.

## Test plan
- Reset hold, then release: all outputs 0; `req_ready` 0→1 on the first cycle after `reset` falls.
- Immediate request with preset=4'hD into a free-running counter: `load`=1 with `load_data`=D for one cycle; `count`=D next cycle; `done`=1 and `err`=0 one cycle later.
- Trigger request with trigger=4'h6, preset=4'h2 while the counter counts from 0: `load` is high in the cycle after `count`=6; `count` then reads 2; `done` pulses.
- Push 5 requests back-to-back with DEPTH=4:
  - `level` reaches 4 and `req_ready`=0 on the 5th push.
  - `level` drops to 3 when the FSM pops the head. The 5th request is accepted once `req_ready` returns.
  - All accepted entries load in push order, with `load` pulses 3 cycles apart for immediate requests.
- Counter held in reset during LOAD, so `count` stays 0 with preset=4'h9: `done`=1 and `err`=1.
- Trigger 4'hF is pending in ARM; assert `flush`, then `reset`, at different points: no `load` or `done` follows, `level`=0, `busy`=0 next cycle. A push in the flush cycle is dropped.

Source files
------------

// File: rtl/count_preset_sched.sv
// Preset sequencer for a loadable counter: queues preset requests and pulses
// load/load_data when the counter reaches the trigger value, then checks the result.
module count_preset_sched #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [WIDTH-1:0]         req_preset,
   input  logic [WIDTH-1:0]         req_trigger,
   input  logic                     req_immediate,
   input  logic [WIDTH-1:0]         count,
   output logic                     load,
   output logic [WIDTH-1:0]         load_data,
   output logic                     done,
   output logic                     err,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_LOAD  = 2'd2,
      S_CHECK = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [WIDTH-1:0] hold_pre_q, hold_pre_d;
   logic [WIDTH-1:0] hold_trig_q, hold_trig_d;
   logic            hold_imm_q, hold_imm_d;
   logic            load_q, load_d;
   logic [WIDTH-1:0] load_data_q, load_data_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [WIDTH-1:0] fifo_pre_q  [DEPTH];
   logic [WIDTH-1:0] fifo_trig_q [DEPTH];
   logic             fifo_imm_q  [DEPTH];

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;
   logic fire_s;

   assign full_s    = (level_q == LW'(DEPTH));
   assign empty_s   = (level_q == LW'(0));
   assign req_ready = !full_s && !reset;
   assign load      = load_q;
   assign load_data = load_data_q;
   assign done      = done_q;
   assign err       = err_q;
   assign busy      = (state_q != S_IDLE);
   assign level     = level_q;

   // Next-state, FIFO bookkeeping and registered output values.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      hold_pre_d  = hold_pre_q;
      hold_trig_d = hold_trig_q;
      hold_imm_d  = hold_imm_q;
      load_d      = 1'b0;
      load_data_d = load_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      pop_s       = 1'b0;
      fire_s      = hold_imm_q || (count == hold_trig_q);
      push_s      = req_valid && req_ready && !flush;

      case (state_q)
         S_IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_d = S_ARM;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARM: begin
            if (fire_s) begin
               load_d      = 1'b1;
               load_data_d = hold_pre_q;
               state_d     = S_LOAD;
            end else begin
               state_d = S_ARM;
            end
         end
         S_LOAD: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            done_d = 1'b1;
            err_d  = (count != hold_pre_q);
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_d = S_ARM;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (pop_s) begin
         hold_pre_d  = fifo_pre_q[rd_ptr_q];
         hold_trig_d = fifo_trig_q[rd_ptr_q];
         hold_imm_d  = fifo_imm_q[rd_ptr_q];
         rd_ptr_d    = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

      // Flush drops the queue and the held entry and suppresses any pending pulse.
      if (flush) begin
         state_d     = S_IDLE;
         wr_ptr_d    = AW'(0);
         rd_ptr_d    = AW'(0);
         level_d     = LW'(0);
         load_d      = 1'b0;
         load_data_d = load_data_q;
         done_d      = 1'b0;
         err_d       = 1'b0;
      end else begin
         load_data_d = load_data_d;
      end
   end

   // State, pointer, holding and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= AW'(0);
         rd_ptr_q    <= AW'(0);
         level_q     <= LW'(0);
         hold_pre_q  <= WIDTH'(0);
         hold_trig_q <= WIDTH'(0);
         hold_imm_q  <= 1'b0;
         load_q      <= 1'b0;
         load_data_q <= WIDTH'(0);
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         hold_pre_q  <= hold_pre_d;
         hold_trig_q <= hold_trig_d;
         hold_imm_q  <= hold_imm_d;
         load_q      <= load_d;
         load_data_q <= load_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   // Request storage; written only on an accepted push.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            fifo_pre_q[i]  <= WIDTH'(0);
            fifo_trig_q[i] <= WIDTH'(0);
            fifo_imm_q[i]  <= 1'b0;
         end
      end else if (push_s) begin
         fifo_pre_q[wr_ptr_q]  <= req_preset;
         fifo_trig_q[wr_ptr_q] <= req_trigger;
         fifo_imm_q[wr_ptr_q]  <= req_immediate;
      end else begin
         fifo_pre_q[wr_ptr_q]  <= fifo_pre_q[wr_ptr_q];
      end
   end

endmodule

// File: tb/tb_count_preset_sched.sv
// Directed bench for count_preset_sched with a loadable-counter model and a
// scoreboard of expected loads in push order.
module tb_count_preset_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, flush, req_valid, req_ready, req_immediate;
   logic [3:0] req_preset, req_trigger, count, load_data;
   logic       load, done, err, busy;
   logic [2:0] level;
   logic       cnt_rst;
   logic [3:0] cnt_q;

   count_preset_sched #(.WIDTH(4), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_preset(req_preset), .req_trigger(req_trigger), .req_immediate(req_immediate),
      .count(count), .load(load), .load_data(load_data),
      .done(done), .err(err), .busy(busy), .level(level)
   );

   // Counter model: its own reset, then load, then increment (wraps 15->0).
   always @(posedge clk) begin
      if (cnt_rst) cnt_q <= 4'h0;
      else if (load) cnt_q <= load_data;
      else cnt_q <= cnt_q + 4'h1;
   end
   assign count = cnt_q;

   typedef struct packed {
      logic [3:0] pre;
      logic [3:0] trig;
      logic       imm;
   } req_t;

   req_t       exp_q[$];
   int         n_tests = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         last_load = 0;
   bit         have_last = 1'b0;
   bit         strict_gap = 1'b0;
   bit         chk_pend = 1'b0;
   bit         done_pend = 1'b0;
   logic       done_exp_err = 1'b0;
   logic [3:0] chk_pre = 4'h0;
   logic [3:0] prev_cnt = 4'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_exp();
      exp_q.delete();
      chk_pend  = 1'b0;
      done_pend = 1'b0;
      have_last = 1'b0;
   endtask

   // One clock, then scoreboard/monitor checks on the post-edge outputs.
   task automatic tick();
      req_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (done_pend) begin
         check("done_pulse", {31'd0, done}, 32'd1);
         check("err_flag", {31'd0, err}, {31'd0, done_exp_err});
         done_pend = 1'b0;
      end else if (done) begin
         check("unexpected_done", {31'd0, done}, 32'd0);
      end
      if (err && !done) check("err_without_done", {31'd0, err}, 32'd0);
      if (chk_pend) begin
         done_exp_err = (count != chk_pre);
         done_pend    = 1'b1;
         chk_pend     = 1'b0;
      end
      if (load) begin
         if (exp_q.size() == 0) begin
            check("unexpected_load", {31'd0, load}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("load_data", {28'd0, load_data}, {28'd0, e.pre});
            if (!e.imm) check("trigger_hit", {28'd0, prev_cnt}, {28'd0, e.trig});
            if (have_last) begin
               if (strict_gap) check("load_gap3", cyc - last_load, 32'd3);
               else check("load_gap_min", {31'd0, (cyc - last_load) >= 3}, 32'd1);
            end
            chk_pend  = 1'b1;
            chk_pre   = e.pre;
            last_load = cyc;
            have_last = 1'b1;
         end
      end
      prev_cnt = count;
   endtask

   task automatic push_req(input logic [3:0] p, input logic [3:0] t, input logic imm);
      int n = 0;
      req_valid     = 1'b1;
      req_preset    = p;
      req_trigger   = t;
      req_immediate = imm;
      while (!req_ready && n < 60) begin
         tick();
         n++;
      end
      check("push_ready_timeout", {31'd0, req_ready}, 32'd1);
      if (req_ready) exp_q.push_back('{pre: p, trig: t, imm: imm});
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_load();
      int n = 0;
      while (!load && n < 40) begin
         tick();
         n++;
      end
      check("load_timeout", {31'd0, load}, 32'd1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || level != 3'd0 || chk_pend || done_pend) && n < 200) begin
         tick();
         n++;
      end
      check("drain", {29'd0, busy, level != 3'd0, exp_q.size() != 0}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0;
      req_preset = 4'h0; req_trigger = 4'h0; req_immediate = 1'b0;
      cnt_rst = 1'b1;

      // Reset hold then release
      repeat (3) tick();
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_load", {31'd0, load}, 32'd0);
      check("rst_load_data", {28'd0, load_data}, 32'd0);
      check("rst_done_err", {30'd0, done, err}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_level", {29'd0, level}, 32'd0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", {31'd0, req_ready}, 32'd1);
      cnt_rst = 1'b0;

      // Immediate preset D: load in cycle 3, done in cycle 5
      push_req(4'hD, 4'h0, 1'b1);
      check("imm_c1_level", {29'd0, level}, 32'd1);
      check("imm_c1_load", {31'd0, load}, 32'd0);
      tick();
      check("imm_c2_busy", {31'd0, busy}, 32'd1);
      check("imm_c2_load", {31'd0, load}, 32'd0);
      tick();
      check("imm_c3_load", {31'd0, load}, 32'd1);
      tick();
      check("imm_c4_done", {31'd0, done}, 32'd0);
      tick();
      check("imm_c5_done", {31'd0, done}, 32'd1);
      check("imm_c5_err", {31'd0, err}, 32'd0);
      wait_idle();

      // Trigger 6, preset 2, counter counting from 0
      cnt_rst = 1'b1;
      tick();
      push_req(4'h2, 4'h6, 1'b0);
      repeat (3) tick();
      check("trig_armed_busy", {31'd0, busy}, 32'd1);
      check("trig_armed_noload", {31'd0, load}, 32'd0);
      cnt_rst = 1'b0;
      wait_load();
      tick();
      tick();
      check("trig_done", {31'd0, done}, 32'd1);
      wait_idle();

      // Trigger 0 matches after the counter wraps
      push_req(4'h5, 4'h0, 1'b0);
      wait_load();
      wait_idle();

      // Counter held in reset: count stays 0, preset 9 -> err
      cnt_rst = 1'b1;
      push_req(4'h9, 4'h0, 1'b1);
      wait_load();
      tick();
      tick();
      check("err_case_done", {31'd0, done}, 32'd1);
      check("err_case_err", {31'd0, err}, 32'd1);
      wait_idle();

      // Blocking trigger, then fill FIFO to 4 and stall the 5th push
      tick();
      push_req(4'h1, 4'hF, 1'b0);
      repeat (2) tick();
      push_req(4'hA, 4'h0, 1'b1);
      push_req(4'hB, 4'h0, 1'b1);
      push_req(4'hC, 4'h0, 1'b1);
      push_req(4'hE, 4'h0, 1'b1);
      check("full_level", {29'd0, level}, 32'd4);
      check("full_ready", {31'd0, req_ready}, 32'd0);
      req_valid = 1'b1; req_preset = 4'h7; req_trigger = 4'h0; req_immediate = 1'b1;
      strict_gap = 1'b1;
      have_last  = 1'b0;
      cnt_rst    = 1'b0;
      for (int n = 0; n < 60 && level == 3'd4; n++) tick();
      check("pop_level3", {29'd0, level}, 32'd3);
      check("pop_ready", {31'd0, req_ready}, 32'd1);
      push_req(4'h7, 4'h0, 1'b1);
      wait_idle();
      strict_gap = 1'b0;

      // Flush while trigger F pending, with a push in the same cycle
      cnt_rst = 1'b1;
      push_req(4'h3, 4'hF, 1'b0);
      repeat (3) tick();
      check("flush_pre_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1; req_valid = 1'b1; req_preset = 4'h8; req_immediate = 1'b1;
      clear_exp();
      tick();
      flush = 1'b0; req_valid = 1'b0;
      check("flush_load", {31'd0, load}, 32'd0);
      check("flush_done", {31'd0, done}, 32'd0);
      check("flush_level", {29'd0, level}, 32'd0);
      check("flush_busy", {31'd0, busy}, 32'd0);
      cnt_rst = 1'b0;
      repeat (20) tick();
      check("flush_after_level", {29'd0, level}, 32'd0);

      // Reset while trigger F pending
      cnt_rst = 1'b1;
      push_req(4'h3, 4'hF, 1'b0);
      repeat (2) tick();
      reset = 1'b1;
      #1;
      check("rst_mid_ready", {31'd0, req_ready}, 32'd0);
      clear_exp();
      tick();
      reset = 1'b0;
      check("rst_mid_load", {31'd0, load}, 32'd0);
      check("rst_mid_load_data", {28'd0, load_data}, 32'd0);
      check("rst_mid_level", {29'd0, level}, 32'd0);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      cnt_rst = 1'b0;
      repeat (20) tick();

      // Flush in CHECK suppresses done/err
      push_req(4'h6, 4'h0, 1'b1);
      wait_load();
      tick();
      flush = 1'b1;
      clear_exp();
      tick();
      flush = 1'b0;
      check("flush_chk_done", {30'd0, done, err}, 32'd0);
      check("flush_chk_busy", {31'd0, busy}, 32'd0);
      repeat (3) tick();

      // Reset during LOAD
      push_req(4'hB, 4'h0, 1'b1);
      wait_load();
      reset = 1'b1;
      clear_exp();
      tick();
      reset = 1'b0;
      check("rst_load_low", {31'd0, load}, 32'd0);
      check("rst_load_done", {31'd0, done}, 32'd0);
      repeat (4) tick();
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
